// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: forwarding select, load-use and memory stalls, branch flush FSM.
// Optional single-step debug hold is built when DEBUG_STEP_EN is defined.
module pipe_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int BR_PENALTY  = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      id_rs_addr,
    input  logic [ADDR_W-1:0]      id_rt_addr,
    input  logic                   id_rs_used,
    input  logic                   id_rt_used,
    input  logic                   id_is_branch,
    input  logic                   id_valid,
    input  logic [ADDR_W-1:0]      exe_wb_addr,
    input  logic                   exe_wb_wen,
    input  logic                   exe_mem_ren,
    input  logic [ADDR_W-1:0]      mem_wb_addr,
    input  logic                   mem_wb_wen,
    input  logic                   dmem_req,
    input  logic                   dmem_ack,
`ifdef DEBUG_STEP_EN
    input  logic                   debug_en,
    input  logic                   debug_step,
`endif
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   if_en,
    output logic                   id_en,
    output logic                   exe_en,
    output logic                   mem_en,
    output logic                   wb_en,
    output logic                   if_rst,
    output logic                   id_rst,
    output logic                   exe_rst,
    output logic                   mem_rst,
    output logic                   wb_rst,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   flushing
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             br_cnt_q, br_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   rs_hit, rt_hit;
    logic                   rs_exe, rt_exe;
    logic                   load_use, mem_wait, dbg_hold;
    logic                   stall_evt;

`ifdef DEBUG_STEP_EN
    logic step_prev;

    always_ff @(posedge clk) begin
        if (rst) step_prev <= 1'b0;
        else     step_prev <= debug_step;
    end

    // A rising edge on debug_step releases the hold for one cycle
    assign dbg_hold = debug_en && !(debug_step && !step_prev);
`else
    assign dbg_hold = 1'b0;
`endif

    assign rs_hit = id_rs_used && (id_rs_addr != '0);
    assign rt_hit = id_rt_used && (id_rt_addr != '0);
    assign rs_exe = rs_hit && (id_rs_addr == exe_wb_addr) && exe_wb_wen;
    assign rt_exe = rt_hit && (id_rt_addr == exe_wb_addr) && exe_wb_wen;

    always_comb begin
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (rs_exe && !exe_mem_ren)
            fwd_a_sel = 2'd1;
        else if (rs_hit && (id_rs_addr == mem_wb_addr) && mem_wb_wen)
            fwd_a_sel = 2'd2;
        if (rt_exe && !exe_mem_ren)
            fwd_b_sel = 2'd1;
        else if (rt_hit && (id_rt_addr == mem_wb_addr) && mem_wb_wen)
            fwd_b_sel = 2'd2;
    end

    assign load_use  = (rs_exe || rt_exe) && exe_mem_ren;
    assign mem_wait  = dmem_req && !dmem_ack;
    assign stall_evt = !rst && !dbg_hold && (mem_wait || load_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            br_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            br_cnt_q <= br_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        br_cnt_d = br_cnt_q;
        if_en    = 1'b1;
        id_en    = 1'b1;
        exe_en   = 1'b1;
        mem_en   = 1'b1;
        wb_en    = 1'b1;
        if_rst   = 1'b0;
        id_rst   = 1'b0;
        exe_rst  = 1'b0;
        mem_rst  = 1'b0;
        wb_rst   = 1'b0;
        if (rst) begin
            if_rst  = 1'b1;
            id_rst  = 1'b1;
            exe_rst = 1'b1;
            mem_rst = 1'b1;
            wb_rst  = 1'b1;
        end else if (dbg_hold || mem_wait) begin
            if_en  = 1'b0;
            id_en  = 1'b0;
            exe_en = 1'b0;
            mem_en = 1'b0;
            wb_en  = 1'b0;
        end else if (load_use) begin
            // Bubble into EXE; a branch in ID waits for the next cycle
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_valid && id_is_branch) begin
                        id_rst   = 1'b1;
                        br_cnt_d = 3'(BR_PENALTY - 1);
                        if (BR_PENALTY > 1) state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    id_rst   = 1'b1;
                    br_cnt_d = br_cnt_q - 3'd1;
                    if (br_cnt_q == 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall_evt && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
    assign flushing  = (state_q == FLUSH) && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with a second narrow-counter instance.
// Debug-step checks are compiled only when DEBUG_STEP_EN is defined.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr;
    logic       id_rs_used, id_rt_used;
    logic       id_is_branch, id_valid;
    logic [4:0] exe_wb_addr;
    logic       exe_wb_wen, exe_mem_ren;
    logic [4:0] mem_wb_addr;
    logic       mem_wb_wen;
    logic       dmem_req, dmem_ack;
    logic       debug_en, debug_step;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic [15:0] stall_cnt;
    logic        flushing;

    logic [1:0]  n_fa, n_fb;
    logic        n_ife, n_ide, n_exe, n_mee, n_wbe;
    logic        n_ifr, n_idr, n_exr, n_mer, n_wbr;
    logic [1:0]  n_stall;
    logic        n_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_branch(id_is_branch), .id_valid(id_valid),
        .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen),
        .exe_mem_ren(exe_mem_ren),
        .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst),
        .mem_rst(mem_rst), .wb_rst(wb_rst),
        .stall_cnt(stall_cnt), .flushing(flushing)
    );

    pipe_ctrl #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_branch(id_is_branch), .id_valid(id_valid),
        .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen),
        .exe_mem_ren(exe_mem_ren),
        .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
`ifdef DEBUG_STEP_EN
        .debug_en(debug_en), .debug_step(debug_step),
`endif
        .fwd_a_sel(n_fa), .fwd_b_sel(n_fb),
        .if_en(n_ife), .id_en(n_ide), .exe_en(n_exe),
        .mem_en(n_mee), .wb_en(n_wbe),
        .if_rst(n_ifr), .id_rst(n_idr), .exe_rst(n_exr),
        .mem_rst(n_mer), .wb_rst(n_wbr),
        .stall_cnt(n_stall), .flushing(n_flush)
    );

    wire [4:0] en_v  = {if_en, id_en, exe_en, mem_en, wb_en};
    wire [4:0] rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
    wire [17:0] n_all = {n_fa, n_fb, n_ife, n_ide, n_exe, n_mee, n_wbe,
                         n_ifr, n_idr, n_exr, n_mer, n_wbr, n_stall, n_flush};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        id_rs_addr = '0; id_rt_addr = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_is_branch = 1'b0; id_valid = 1'b0;
        exe_wb_addr = '0; exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        mem_wb_addr = '0; mem_wb_wen = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0;
        debug_en = 1'b0; debug_step = 1'b0;

        tick(); tick();
        settle();
        chk("reset_rst", 32'(rst_v), 32'h1f);
        chk("reset_en", 32'(en_v), 32'h1f);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush", 32'(flushing), 32'd0);

        // EXE forwarding, EXE beats MEM
        rst = 1'b0;
        id_rs_addr = 5'd3; id_rs_used = 1'b1;
        exe_wb_addr = 5'd3; exe_wb_wen = 1'b1;
        settle();
        chk("fwd_exe", 32'(fwd_a_sel), 32'd1);
        chk("fwd_exe_en", 32'(en_v), 32'h1f);
        chk("fwd_exe_rst", 32'(rst_v), 32'h00);
        mem_wb_addr = 5'd3; mem_wb_wen = 1'b1;
        settle();
        chk("fwd_exe_prec", 32'(fwd_a_sel), 32'd1);
        exe_wb_wen = 1'b0;
        id_rt_addr = 5'd7; id_rt_used = 1'b1;
        settle();
        chk("fwd_mem_a", 32'(fwd_a_sel), 32'd2);
        chk("fwd_rt_none", 32'(fwd_b_sel), 32'd0);
        mem_wb_addr = 5'd7;
        settle();
        chk("fwd_mem_b", 32'(fwd_b_sel), 32'd2);

        // Register 0 never matches
        tick();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0;
        exe_wb_addr = 5'd0; exe_wb_wen = 1'b1; exe_mem_ren = 1'b1;
        mem_wb_addr = 5'd0;
        settle();
        chk("zero_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        chk("zero_en", 32'(en_v), 32'h1f);
        tick();
        chk("zero_cnt", 32'(stall_cnt), 32'd0);

        // Load-use on rt
        id_rs_used = 1'b0; mem_wb_wen = 1'b0;
        id_rt_addr = 5'd5; exe_wb_addr = 5'd5;
        settle();
        chk("lu_en", 32'(en_v), 32'h07);
        chk("lu_rst", 32'(rst_v), 32'h04);
        chk("lu_fwd", 32'(fwd_b_sel), 32'd0);
        chk("lu_cnt0", 32'(stall_cnt), 32'd0);
        tick();
        exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        settle();
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);
        chk("lu_clear_en", 32'(en_v), 32'h1f);
        chk("lu_clear_rst", 32'(rst_v), 32'h00);

        // Branch flush, id_is_branch held high to show it is ignored
        id_valid = 1'b1; id_is_branch = 1'b1;
        settle();
        chk("br_n_rst", 32'(rst_v), 32'h08);
        chk("br_n_flush", 32'(flushing), 32'd0);
        tick();
        chk("br_n1_rst", 32'(rst_v), 32'h08);
        chk("br_n1_flush", 32'(flushing), 32'd1);
        tick();
        chk("br_n2_rst", 32'(rst_v), 32'h08);
        chk("br_n2_flush", 32'(flushing), 32'd1);
        tick();
        id_is_branch = 1'b0;
        settle();
        chk("br_n3_rst", 32'(rst_v), 32'h00);
        chk("br_n3_flush", 32'(flushing), 32'd0);

        // Branch then a 4-cycle memory wait freezes the flush
        id_is_branch = 1'b1;
        settle();
        chk("bw_n_rst", 32'(rst_v), 32'h08);
        tick();
        id_is_branch = 1'b0;
        dmem_req = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bw_wait_en", 32'(en_v), 32'h00);
            chk("bw_wait_rst", 32'(rst_v), 32'h00);
            chk("bw_wait_flush", 32'(flushing), 32'd1);
            tick();
        end
        dmem_ack = 1'b1;
        settle();
        chk("bw_ack_en", 32'(en_v), 32'h1f);
        chk("bw_res1_rst", 32'(rst_v), 32'h08);
        chk("bw_cnt", 32'(stall_cnt), 32'd5);
        chk("sat_all", 32'(n_all), 32'({2'd0, 2'd0, 5'h1f, 5'h08, 2'd3, 1'b1}));
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0;
        settle();
        chk("bw_res2_rst", 32'(rst_v), 32'h08);
        chk("bw_res2_flush", 32'(flushing), 32'd1);
        tick();
        chk("bw_done_rst", 32'(rst_v), 32'h00);
        chk("bw_done_flush", 32'(flushing), 32'd0);
        chk("sat_cnt", 32'(n_stall), 32'd3);

        // Load-use concurrent with a branch defers the branch
        id_is_branch = 1'b1;
        id_rs_addr = 5'd9; id_rs_used = 1'b1;
        exe_wb_addr = 5'd9; exe_wb_wen = 1'b1; exe_mem_ren = 1'b1;
        settle();
        chk("def_rst", 32'(rst_v), 32'h04);
        chk("def_en", 32'(en_v), 32'h07);
        tick();
        exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        settle();
        chk("def_acc_rst", 32'(rst_v), 32'h08);
        chk("def_acc_flush", 32'(flushing), 32'd0);
        chk("def_cnt", 32'(stall_cnt), 32'd6);
        tick();
        id_is_branch = 1'b0;
        settle();
        chk("def_flush", 32'(flushing), 32'd1);

        // Reset in the middle of a flush
        rst = 1'b1;
        settle();
        chk("mid_rst_rst", 32'(rst_v), 32'h1f);
        chk("mid_rst_en", 32'(en_v), 32'h1f);
        chk("mid_rst_flush", 32'(flushing), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("post_rst_flush", 32'(flushing), 32'd0);
        chk("post_rst_rst", 32'(rst_v), 32'h00);
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

`ifdef DEBUG_STEP_EN
        id_valid = 1'b0;
        debug_en = 1'b1; debug_step = 1'b0;
        settle();
        chk("dbg_hold", 32'(en_v), 32'h00);
        tick();
        debug_step = 1'b1;
        settle();
        chk("dbg_step", 32'(en_v), 32'h1f);
        tick();
        settle();
        chk("dbg_rehold", 32'(en_v), 32'h00);
        tick();
        settle();
        chk("dbg_hold2", 32'(en_v), 32'h00);
        debug_en = 1'b0; debug_step = 1'b0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Clocking and reset SHALL be one clock and a synchronous active-high reset: clk drives all state; rst resets all state on a rising clk edge.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register address width.
REQ-003 Parameter BR_PENALTY, default 3, legal range 1..7, SHALL set the number of ID flush cycles per jump/branch.
REQ-004 Parameter STALL_CNT_W, default 16, SHALL set the stall counter width.
REQ-005 Ports SHALL be:
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- id_rs_addr, id_rt_addr  in  ADDR_W  ID source register addresses
- id_rs_used, id_rt_used  in  1  ID instruction reads rs/rt
- id_is_branch  in  1  ID holds a decoded jump/branch
- id_valid  in  1  ID stage valid
- exe_wb_addr  in  ADDR_W; exe_wb_wen  in  1; exe_mem_ren  in  1  EXE destination, write enable, load flag
- mem_wb_addr  in  ADDR_W; mem_wb_wen  in  1  MEM destination, write enable
- dmem_req  in  1  MEM stage access outstanding
- dmem_ack  in  1  data memory completes access this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand source: 0 regfile, 1 EXE result, 2 MEM result
- if_en, id_en, exe_en, mem_en, wb_en  out  1  stage enables
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1  stage resets (bubble insert)
- stall_cnt  out  STALL_CNT_W  saturating count of hazard stall cycles
- flushing  out  1  branch FSM in FLUSH
- debug_en, debug_step  in  1  present only with DEBUG_STEP_EN

Function
REQ-006 Forwarding (combinational): per operand, match = used && addr!=0; EXE match with exe_wb_wen && !exe_mem_ren -> 1; else MEM match with mem_wb_wen -> 2; else 0; EXE takes precedence over MEM.
REQ-007 Load-use hazard SHALL be asserted when a used nonzero rs/rt equals exe_wb_addr with exe_wb_wen && exe_mem_ren; no stall for ALU-result dependencies.
REQ-008 Memory wait SHALL be dmem_req && !dmem_ack.
REQ-009 Priority, highest first: rst (all *_rst=1) > debug hold > memory wait > load-use > branch flush; defaults all *_en=1, all *_rst=0.
REQ-010 Debug hold and memory wait SHALL deassert all five *_en, assert no *_rst, and freeze FSM and counter.
REQ-011 Load-use SHALL drive if_en=0, id_en=0, exe_rst=1 for exactly one cycle per hazard.
REQ-012 Branch FSM states IDLE, FLUSH with counter br_cnt (3 bits): IDLE and id_valid && id_is_branch and no higher-priority condition -> id_rst=1, br_cnt<=BR_PENALTY-1, go FLUSH if BR_PENALTY>1, else stay IDLE.
REQ-013 In FLUSH: id_rst=1, flushing=1, br_cnt decrements; at br_cnt==1 -> IDLE next cycle; id_is_branch ignored while FLUSH.
REQ-014 A load-use cycle concurrent with a branch in ID SHALL defer the branch; the branch is accepted the cycle after the stall clears.
REQ-015 Total id_rst cycles per accepted branch SHALL equal BR_PENALTY, excluding frozen cycles.
REQ-016 stall_cnt SHALL increment by 1 on each memory-wait or load-use cycle, saturating at all-ones.

Reset
REQ-017 On rst: FSM=IDLE, br_cnt=0, stall_cnt=0, flushing=0, all *_rst=1, all *_en=1; fwd_*_sel follow inputs; an in-progress flush or stall is abandoned.

Configuration
REQ-018 Macro DEBUG_STEP_EN: when defined, debug_en/debug_step ports exist, debug_step is registered (step_prev), and debug_en && !(debug_step && !step_prev) is debug hold; when undefined, ports are absent and debug hold never occurs.

Verification
REQ-019 id_rs=3 used, exe_wb_addr=3, exe_wb_wen=1, exe_mem_ren=0 -> fwd_a_sel=1, no stall; also mem_wb_addr=3 wen=1 -> still 1.
REQ-020 id_rt=5 used, exe_wb_addr=5, wen=1, mem_ren=1 -> one cycle if_en=id_en=0, exe_rst=1; stall_cnt 0->1.
REQ-021 BR_PENALTY=3, branch in ID at cycle N -> id_rst=1 in N, N+1, N+2, flushing=1 in N+1, N+2, 0 at N+3.
REQ-022 Branch flush at cycle N+1, dmem_req=1, dmem_ack=0 for 4 cycles -> all *_en=0, id_rst=0, FSM frozen; flush resumes, 3 id_rst cycles total; stall_cnt +4.
REQ-023 addr 0 dependency with exe_wb_addr=0 -> fwd_*_sel=0, no stall; STALL_CNT_W=2 with 5 stalls -> stall_cnt=3.
REQ-024 rst mid-flush -> next cycle FSM IDLE, flushing=0, stall_cnt=0; with DEBUG_STEP_EN, debug_en=1 and one debug_step rising edge -> exactly one cycle of *_en=1.
